// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with one holding slot per producer; define CDB_COUNT_EN to add bc_count/stall_count.
module cdb_arbiter #(
  parameter int NSRC = 3,
  parameter int DATA_W = 32,
  parameter int LABEL_W = 4
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic [NSRC-1:0]           src_valid,
  output logic [NSRC-1:0]           src_ready,
  input  logic [NSRC*DATA_W-1:0]    src_data,
  input  logic [NSRC*LABEL_W-1:0]   src_label,
  output logic                      BCEN,
  output logic [LABEL_W-1:0]        BClabel,
  output logic [DATA_W-1:0]         BCdata
`ifdef CDB_COUNT_EN
  ,
  output logic [31:0]               bc_count,
  output logic [31:0]               stall_count
`endif
);
  localparam int PW = NSRC > 1 ? $clog2(NSRC) : 1;
  logic [NSRC-1:0] slot_vld, grant, load;
  logic [LABEL_W-1:0] slot_label [NSRC];
  logic [DATA_W-1:0] slot_data [NSRC];
  logic [PW-1:0] ptr, win, idx;
  logic found;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = PW'((int'(ptr) + k) % NSRC);
      if (!found && slot_vld[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    grant = found ? NSRC'(1) << win : '0;
  end
  assign src_ready = ~slot_vld | grant;
  always_comb begin
    load = '0;
    for (int k = 0; k < NSRC; k++)
      load[k] = src_valid[k] && src_ready[k] && (src_label[k*LABEL_W +: LABEL_W] != '0);
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      slot_vld <= '0;
      for (int k = 0; k < NSRC; k++) begin
        slot_label[k] <= '0;
        slot_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        if (load[k]) begin
          slot_vld[k] <= 1'b1;
          slot_label[k] <= src_label[k*LABEL_W +: LABEL_W];
          slot_data[k] <= src_data[k*DATA_W +: DATA_W];
        end else if (grant[k]) begin
          slot_vld[k] <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      BCEN <= 1'b0;
      BClabel <= '0;
      BCdata <= '0;
      ptr <= '0;
    end else begin
      BCEN <= found;
      if (found) begin
        BClabel <= slot_label[win];
        BCdata <= slot_data[win];
        ptr <= win == PW'(NSRC - 1) ? '0 : win + 1'b1;
      end
    end
  end
`ifdef CDB_COUNT_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bc_count <= '0;
      stall_count <= '0;
    end else begin
      bc_count <= bc_count + 32'(found);
      stall_count <= stall_count + 32'(|(src_valid & ~src_ready));
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: random and directed stimulus checked cycle by cycle against a behavioural model of the CDB arbiter.
module tb_cdb_arbiter;
  localparam int N = 3, DW = 32, LW = 4;
  logic clk = 1'b0, nRST = 1'b0;
  logic [N-1:0] src_valid, src_ready;
  logic [N*DW-1:0] src_data;
  logic [N*LW-1:0] src_label;
  logic BCEN;
  logic [LW-1:0] BClabel;
  logic [DW-1:0] BCdata;
`ifdef CDB_COUNT_EN
  logic [31:0] bc_count, stall_count;
`endif
  cdb_arbiter #(.NSRC(N), .DATA_W(DW), .LABEL_W(LW)) dut (
    .clk(clk), .nRST(nRST), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_label(src_label), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata)
`ifdef CDB_COUNT_EN
    , .bc_count(bc_count), .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  bit m_vld[N], hold[N], want_v[N], m_bcen;
  logic [LW-1:0] m_lab[N], want_l[N], m_bclab;
  logic [DW-1:0] m_dat[N], want_d[N], m_bcdat;
  int m_ptr;
  logic [31:0] m_bc, m_stall;
  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_vld[j] = 0; hold[j] = 0; m_lab[j] = '0; m_dat[j] = '0;
    end
    m_ptr = 0; m_bcen = 0; m_bclab = '0; m_bcdat = '0; m_bc = 0; m_stall = 0;
  endtask
  task automatic clear_want();
    for (int j = 0; j < N; j++) begin
      want_v[j] = 0; want_l[j] = '0; want_d[j] = '0;
    end
  endtask
  task automatic step();
    int w;
    bit rdy[N];
    @(negedge clk);
    check("bcen", BCEN, m_bcen);
    check("bclabel", BClabel, m_bclab);
    check("bcdata", BCdata, m_bcdat);
`ifdef CDB_COUNT_EN
    check("bc_count", bc_count, m_bc);
    check("stall_count", stall_count, m_stall);
`endif
    // oldest-pointer round robin: first valid slot at or after m_ptr, wrapping
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && m_vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    for (int j = 0; j < N; j++) begin
      rdy[j] = !m_vld[j] || (w == j);
      check($sformatf("ready%0d", j), src_ready[j], rdy[j]);
      if (!hold[j]) begin
        src_valid[j] = want_v[j];
        src_label[j*LW +: LW] = want_l[j];
        src_data[j*DW +: DW] = want_d[j];
      end
    end
    if (w >= 0) begin
      m_bcen = 1; m_bclab = m_lab[w]; m_bcdat = m_dat[w]; m_ptr = (w + 1) % N; m_bc++;
    end else m_bcen = 0;
    for (int j = 0; j < N; j++)
      if (src_valid[j] && !rdy[j]) begin
        m_stall++;
        break;
      end
    for (int j = 0; j < N; j++) begin
      if (src_valid[j] && rdy[j] && src_label[j*LW +: LW] != 0) begin
        m_vld[j] = 1; m_lab[j] = src_label[j*LW +: LW]; m_dat[j] = src_data[j*DW +: DW];
      end else if (w == j) m_vld[j] = 0;
      hold[j] = src_valid[j] && !rdy[j];
    end
  endtask
  initial begin
    int nxt;
    src_valid = '0; src_data = '0; src_label = '0;
    model_reset();
    clear_want();
    repeat (3) @(negedge clk);
    check("rst_bcen", BCEN, 0);
    check("rst_ready", src_ready, 3'b111);
    nRST = 1'b1;
    repeat (10) step();
    want_v[1] = 1; want_l[1] = 4'd5; want_d[1] = 32'h1234;
    step();
    clear_want();
    repeat (4) step();
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < N; j++) begin
        want_v[j] = 1; want_l[j] = LW'(j + 1); want_d[j] = 32'hA000 + 32'(j);
      end
      step();
      clear_want();
      repeat (5) step();
    end
    nxt = 1;
    want_v[2] = 1; want_l[2] = 4'd9; want_d[2] = 32'h9999;
    repeat (24) begin
      if (!hold[0] && nxt <= 8) begin
        want_v[0] = 1; want_l[0] = LW'(nxt); want_d[0] = 32'h100 + 32'(nxt); nxt++;
      end else if (!hold[0]) want_v[0] = 0;
      step();
    end
    clear_want();
    repeat (4) step();
    want_v[2] = 1; want_l[2] = '0; want_d[2] = 32'hDEAD;
    step();
    clear_want();
    repeat (3) step();
    foreach (want_v[p]) begin
      int pct;
      pct = 20 + p * 35;
      repeat (600) begin
        for (int j = 0; j < N; j++) begin
          want_v[j] = ($urandom % 100) < pct;
          want_l[j] = LW'($urandom);
          want_d[j] = $urandom;
        end
        step();
      end
    end
    for (int j = 0; j < N; j++) begin
      want_v[j] = 1; want_l[j] = LW'($urandom_range(1, 15)); want_d[j] = $urandom;
    end
    repeat (3) step();
    #2 nRST = 1'b0;
    #1;
    check("async_bcen", BCEN, 0);
    check("async_bclabel", BClabel, 0);
    check("async_bcdata", BCdata, 0);
    src_valid = '0;
    clear_want();
    model_reset();
    @(negedge clk);
    check("rst_ready2", src_ready, 3'b111);
    nRST = 1'b1;
    repeat (6) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
